// File: rtl/flash_read_cache.sv
// Direct-mapped one-word read cache in front of an SPI flash word reader.
// Hits answer on the request edge; misses run a strobe/busy handshake with the reader.
module flash_read_cache #(
    parameter int LINES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_rstrb,
    input  logic [19:0] mem_word_address,
    output logic [31:0] mem_rdata,
    output logic        mem_rbusy,
    input  logic        invalidate,
    output logic        flash_rstrb,
    output logic [19:0] flash_word_address,
    input  logic [31:0] flash_rdata,
    input  logic        flash_rbusy,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
);
    localparam int IDX = $clog2(LINES);
    localparam int TW  = 20 - IDX;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE,
        FILL
    } state_t;

    state_t state, state_nx;

    logic [LINES-1:0] valid;
    logic [TW-1:0]    tags  [LINES];
    logic [31:0]      data  [LINES];

    logic [19:0]    addr_q;
    logic           fill_ok;
    logic [IDX-1:0] idx;
    logic [TW-1:0]  tag;
    logic [IDX-1:0] fill_idx;
    logic           hit;

    assign idx      = mem_word_address[IDX-1:0];
    assign tag      = mem_word_address[19:IDX];
    assign fill_idx = addr_q[IDX-1:0];
    // A same-cycle invalidate turns a would-be hit into a miss.
    assign hit      = valid[idx] && (tags[idx] == tag) && !invalidate;

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:      if (mem_rstrb && !hit) state_nx = ISSUE;
            ISSUE:     state_nx = WAIT_BUSY;
            WAIT_BUSY: if (flash_rbusy) state_nx = WAIT_DONE;
            WAIT_DONE: if (!flash_rbusy) state_nx = FILL;
            FILL:      state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            mem_rdata          <= '0;
            mem_rbusy          <= 1'b0;
            flash_rstrb        <= 1'b0;
            flash_word_address <= '0;
            hit_count          <= '0;
            miss_count         <= '0;
            valid              <= '0;
            addr_q             <= '0;
            fill_ok            <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (mem_rstrb && hit) begin
                        mem_rdata <= data[idx];
                        if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
                    end else if (mem_rstrb) begin
                        addr_q             <= mem_word_address;
                        flash_word_address <= mem_word_address;
                        mem_rbusy          <= 1'b1;
                        fill_ok            <= 1'b1;
                        if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
                    end
                end
                ISSUE:     flash_rstrb <= 1'b1;
                WAIT_BUSY: if (flash_rbusy) flash_rstrb <= 1'b0;
                WAIT_DONE: if (!flash_rbusy) mem_rdata <= flash_rdata;
                FILL:      mem_rbusy <= 1'b0;
                default:   ;
            endcase
            // Data fetched across an invalidate may be stale, so it is not cached.
            if (invalidate && state != IDLE) fill_ok <= 1'b0;
            if (invalidate)
                valid <= '0;
            else if (state == FILL && fill_ok)
                valid[fill_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (state == FILL) begin
            tags[fill_idx] <= addr_q[19:IDX];
            data[fill_idx] <= mem_rdata;
        end
    end

endmodule
